// File: rtl/spi_slave_if.sv
// spi_slave_if: host-side configuration, word and handshake signals of spi_slave.
interface spi_slave_if;
    logic [1:0]  spi_mode;
    logic [1:0]  word_len;
    logic [31:0] tx_data;
    logic        tx_load;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ack;
    logic        busy;
    logic        overrun;
    modport master (
        output spi_mode, word_len, tx_data, tx_load, rx_ack,
        input  tx_ready, rx_data, rx_valid, busy, overrun
    );
    modport slave (
        input  spi_mode, word_len, tx_data, tx_load, rx_ack,
        output tx_ready, rx_data, rx_valid, busy, overrun
    );
endinterface

// File: rtl/spi_slave.sv
// spi_slave: oversampled SPI slave, 4/8/16/32-bit MSB-first words, all four modes.
// Optional sticky overrun detection is built only when SPIS_OVERRUN_EN is defined.
module spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       GCLK,
    input  logic       RST,
    spi_slave_if.slave host,
    input  logic       i_SCK,
    input  logic       i_CS,
    input  logic       i_MOSI,
    output logic       o_MISO,
    output logic       o_MISO_oe
);
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d, cs_sync_q, cs_sync_d, mosi_sync_q, mosi_sync_d;
    logic                   sck_prev_q, sck_prev_d, cs_prev_q, cs_prev_d;
    logic [SYNC_STAGES:0]   settle_q, settle_d;
    logic                   armed_q, armed_d, cpha_q, cpha_d, lead_q, lead_d;
    logic [1:0]             len_q, len_d;
    logic [5:0]             cnt_q, cnt_d;
    logic [31:0]            pend_q, pend_d, tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
    logic                   tx_ready_q, tx_ready_d, rx_valid_q, rx_valid_d, miso_q, miso_d;
    logic                   sck_s, cs_s, mosi_s, sck_rise, sck_fall, cs_fall, cs_rise;
    logic                   smp_edge, drv_edge;
    logic [5:0]             nbits;
`ifdef SPIS_OVERRUN_EN
    logic                   ovr_q, ovr_d;
`endif

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    // CS falls only count once the synchronizer holds real samples of an idle bus,
    // so a reset taken with CS low cannot start a frame.
    assign cs_fall  = armed_q & cs_prev_q & ~cs_s;
    assign cs_rise  = cs_s & ~cs_prev_q;
    assign smp_edge = cpha_q ? sck_rise : sck_fall;
    assign drv_edge = cpha_q ? sck_fall : sck_rise;
    assign nbits    = 6'd32 >> len_q;

    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], i_SCK};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], i_CS};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], i_MOSI};
        sck_prev_d  = sck_s;
        cs_prev_d   = cs_s;
        settle_d    = {settle_q[SYNC_STAGES-1:0], 1'b1};
        armed_d     = armed_q | (settle_q[SYNC_STAGES] & cs_s);
        state_d     = state_q;
        cpha_d      = cpha_q;
        lead_d      = lead_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        tx_sh_d     = tx_sh_q;
        rx_sh_d     = rx_sh_q;
        rx_data_d   = rx_data_q;
        tx_ready_d  = tx_ready_q;
        miso_d      = miso_q;
        rx_valid_d  = rx_valid_q & ~host.rx_ack;
`ifdef SPIS_OVERRUN_EN
        ovr_d       = ovr_q;
`endif
        if (state_q == IDLE) begin
            if (cs_fall) begin
                state_d    = SHIFT;
                cpha_d     = host.spi_mode[0];
                // When the idle level makes the first edge a drive edge, that edge is skipped.
                lead_d     = ~(host.spi_mode[1] ^ host.spi_mode[0]);
                len_d      = host.word_len;
                tx_sh_d    = tx_ready_q ? 32'd0 : pend_q;
                tx_ready_d = 1'b1;
                cnt_d      = 6'd0;
                rx_sh_d    = 32'd0;
                miso_d     = tx_sh_d[31];
            end
        end else if (cs_rise) begin
            state_d = IDLE;
        end else if (state_q == SHIFT) begin
            if (drv_edge) begin
                lead_d = 1'b0;
                if (!lead_q) begin
                    tx_sh_d = tx_sh_q << 1;
                    miso_d  = tx_sh_q[30];
                end
            end
            if (smp_edge) begin
                lead_d                     = 1'b0;
                rx_sh_d[5'd31 - cnt_q[4:0]] = mosi_s;
                cnt_d                      = cnt_q + 6'd1;
                if (cnt_d == nbits) begin
                    state_d    = HOLD;
                    rx_data_d  = rx_sh_d;
                    rx_valid_d = 1'b1;
`ifdef SPIS_OVERRUN_EN
                    ovr_d      = ovr_q | (rx_valid_q & ~host.rx_ack);
`endif
                end
            end
        end
        if (host.tx_load && tx_ready_q) begin
            pend_d     = host.tx_data;
            tx_ready_d = 1'b0;
        end
    end

    always_ff @(posedge GCLK) begin
        if (RST) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b1;
            settle_q    <= '0;
            armed_q     <= 1'b0;
            state_q     <= IDLE;
            cpha_q      <= 1'b0;
            lead_q      <= 1'b0;
            len_q       <= 2'd0;
            cnt_q       <= 6'd0;
            pend_q      <= 32'd0;
            tx_sh_q     <= 32'd0;
            rx_sh_q     <= 32'd0;
            rx_data_q   <= 32'd0;
            tx_ready_q  <= 1'b1;
            rx_valid_q  <= 1'b0;
            miso_q      <= 1'b0;
`ifdef SPIS_OVERRUN_EN
            ovr_q       <= 1'b0;
`endif
        end else begin
            sck_sync_q  <= sck_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sck_prev_q  <= sck_prev_d;
            cs_prev_q   <= cs_prev_d;
            settle_q    <= settle_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            cpha_q      <= cpha_d;
            lead_q      <= lead_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            tx_sh_q     <= tx_sh_d;
            rx_sh_q     <= rx_sh_d;
            rx_data_q   <= rx_data_d;
            tx_ready_q  <= tx_ready_d;
            rx_valid_q  <= rx_valid_d;
            miso_q      <= miso_d;
`ifdef SPIS_OVERRUN_EN
            ovr_q       <= ovr_d;
`endif
        end
    end

    assign host.tx_ready = tx_ready_q;
    assign host.rx_data  = rx_data_q;
    assign host.rx_valid = rx_valid_q;
    assign host.busy     = state_q != IDLE;
`ifdef SPIS_OVERRUN_EN
    assign host.overrun  = ovr_q;
`else
    assign host.overrun  = 1'b0;
`endif
    assign o_MISO        = miso_q;
    assign o_MISO_oe     = ~cs_s;
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: randomized SPI master against spi_slave with a received-word scoreboard.
`timescale 1ns/1ps
module tb_spi_slave;
    logic GCLK = 1'b0;
    logic RST = 1'b1;
    logic i_SCK = 1'b0, i_CS = 1'b1, i_MOSI = 1'b0;
    logic o_MISO, o_MISO_oe;

    spi_slave_if bus();

    spi_slave #(.SYNC_STAGES(2)) dut (
        .GCLK(GCLK), .RST(RST), .host(bus),
        .i_SCK(i_SCK), .i_CS(i_CS), .i_MOSI(i_MOSI),
        .o_MISO(o_MISO), .o_MISO_oe(o_MISO_oe)
    );

    always #5 GCLK = ~GCLK;

    int n_checks = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    bit auto_ack = 1'b1;
    bit seen = 1'b0;
    // Reference state: the word the host has queued for the next frame, if any.
    logic [31:0] pend = 32'd0;
    bit pend_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every new rx_valid is matched against the oldest expected word.
    initial begin
        bus.rx_ack = 1'b0;
        forever begin
            @(negedge GCLK);
            bus.rx_ack = 1'b0;
            if (bus.rx_valid && !seen) begin
                seen = 1'b1;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL rx_unexpected: got %h expected no word", bus.rx_data);
                end else chk("rx_data", bus.rx_data, exp_q.pop_front());
            end
            if (bus.rx_valid && auto_ack) bus.rx_ack = 1'b1;
            if (!bus.rx_valid) seen = 1'b0;
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tx_ready"}, {31'd0, bus.tx_ready}, 32'd1);
        chk({tag, "_rx_valid"}, {31'd0, bus.rx_valid}, 32'd0);
        chk({tag, "_overrun"}, {31'd0, bus.overrun}, 32'd0);
        chk({tag, "_rx_data"}, bus.rx_data, 32'd0);
        chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_miso"}, {31'd0, o_MISO}, 32'd0);
        chk({tag, "_miso_oe"}, {31'd0, o_MISO_oe}, 32'd0);
    endtask

    task automatic load(input logic [31:0] d);
        @(negedge GCLK);
        bus.tx_data = d;
        bus.tx_load = 1'b1;
        if (!pend_valid) begin
            pend = d;
            pend_valid = 1'b1;
        end
        @(negedge GCLK);
        bus.tx_load = 1'b0;
        chk("tx_ready_after_load", {31'd0, bus.tx_ready}, 32'd0);
    endtask

    // Master: sample edge is rising for CPHA=1 and falling for CPHA=0; data changes on the other edge.
    task automatic xfer(input logic [1:0] mode, input logic [1:0] len, input logic [31:0] mo,
                        input int stop, input int rst_at, output logic [31:0] mi);
        int n, h, s;
        logic sck;
        n = 32 >> len;
        h = $urandom_range(4, 8);
        s = 0;
        mi = 32'd0;
        sck = mode[1];
        @(negedge GCLK);
        bus.spi_mode = mode;
        bus.word_len = len;
        i_SCK = mode[1];
        i_MOSI = mo[31];
        i_CS = 1'b0;
        repeat (h + 4) @(negedge GCLK);
        for (int e = 0; e < 2 * n && s < stop; e++) begin
            sck = ~sck;
            if (sck == mode[0]) begin
                mi[31 - s] = o_MISO;
                s++;
            end else if (s > 0 && s < n) i_MOSI = mo[31 - s];
            i_SCK = sck;
            if (s == rst_at) begin
                rst_at = -1;
                RST = 1'b1;
                @(negedge GCLK);
                RST = 1'b0;
                pend_valid = 1'b0;
                check_reset_outputs("midframe_rst");
            end
            repeat (h) @(negedge GCLK);
        end
        i_CS = 1'b1;
        repeat (2) @(negedge GCLK);
        i_SCK = mode[1];
        repeat (8) @(negedge GCLK);
    endtask

    task automatic frame(input string tag, input logic [1:0] mode, input logic [1:0] len,
                         input logic [31:0] mo, input int stop, input int rst_at, input bit push);
        int n;
        logic [31:0] ones, mask, sent, mi;
        n = 32 >> len;
        ones = '1;
        mask = ~(ones >> n);
        sent = pend_valid ? pend : 32'd0;
        pend_valid = 1'b0;
        if (push && stop >= n && rst_at < 0) exp_q.push_back(mo & mask);
        xfer(mode, len, mo, stop, rst_at, mi);
        if (stop >= n && rst_at < 0) chk({tag, "_miso_word"}, mi & mask, sent & mask);
        chk({tag, "_tx_ready"}, {31'd0, bus.tx_ready}, {31'd0, !pend_valid});
        chk({tag, "_busy_end"}, {31'd0, bus.busy}, 32'd0);
        if (push) begin
            for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge GCLK);
            if (exp_q.size() != 0) begin
                n_checks++;
                n_err++;
                $display("FAIL %s_rx_timeout: got no word expected %h", tag, exp_q[0]);
                exp_q.delete();
            end
            repeat (3) @(negedge GCLK);
        end
    endtask

    initial begin
        logic [1:0] m, l;
        logic [31:0] a, b;
        bit exp_ovr;
        bus.spi_mode = 2'd0;
        bus.word_len = 2'd0;
        bus.tx_data = 32'd0;
        bus.tx_load = 1'b0;
        repeat (3) @(negedge GCLK);
        check_reset_outputs("reset");
        RST = 1'b0;
        repeat (10) @(negedge GCLK);

        load(32'hA500_0000);
        frame("mode0_8b", 2'd0, 2'd2, 32'h3C00_0000, 99, -1, 1'b1);
        for (int k = 1; k < 4; k++) begin
            load(32'hDEAD_BEEF);
            frame("mode_n_32b", 2'(k), 2'd0, 32'h1234_5678, 99, -1, 1'b1);
        end
        frame("nil_4b", 2'd0, 2'd3, 32'hB000_0000, 99, -1, 1'b1);

        frame("abort_16b", 2'd0, 2'd1, 32'h1234_0000, 5, -1, 1'b0);
        chk("abort_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        frame("after_abort", 2'd0, 2'd1, 32'h8001_0000, 99, -1, 1'b1);

        for (int k = 0; k < 10; k++) begin
            m = 2'($urandom_range(0, 3));
            l = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) load($urandom);
            if ($urandom_range(0, 3) == 0) load($urandom);
            frame("random", m, l, $urandom, 99, -1, 1'b1);
        end
        chk("overrun_before", {31'd0, bus.overrun}, 32'd0);

        auto_ack = 1'b0;
        a = $urandom & 32'hFF00_0000;
        b = $urandom & 32'hFF00_0000;
        frame("ovr_first", 2'd0, 2'd2, a, 99, -1, 1'b1);
        frame("ovr_second", 2'd0, 2'd2, b, 99, -1, 1'b0);
`ifdef SPIS_OVERRUN_EN
        exp_ovr = 1'b1;
`else
        exp_ovr = 1'b0;
`endif
        chk("ovr_flag", {31'd0, bus.overrun}, {31'd0, exp_ovr});
        chk("ovr_rx_data", bus.rx_data, b);
        chk("ovr_rx_valid", {31'd0, bus.rx_valid}, 32'd1);
        auto_ack = 1'b1;
        repeat (4) @(negedge GCLK);

        load(32'hCAFE_F00D);
        frame("rst_frame", 2'd0, 2'd0, 32'hFFFF_FFFF, 99, 10, 1'b0);
        chk("rst_rx_valid_end", {31'd0, bus.rx_valid}, 32'd0);
        load(32'h0F0F_A5A5);
        frame("after_rst", 2'd3, 2'd0, 32'h5A5A_1234, 99, -1, 1'b1);

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
